// File: rtl/lms_src_gen.sv
// Tone + filtered-LFSR-noise stimulus source for the LMS canceller; outputs registered one edge after each RUN strobe.
// Optional chirp mode (ramping phase increment) is built when LMS_SRC_SWEEP_EN is defined.
module lms_src_gen #(
  parameter logic [15:0] PHASE_INC  = 16'd1024,
  parameter logic [15:0] NOISE_SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              sample_en,
  input  logic [15:0]       burst_len,
  output logic signed [7:0] data,
  output logic signed [7:0] ref_data,
  output logic signed [7:0] clean,
  output logic              valid,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, PRIME, RUN, DONE} state_t;

  state_t            state, state_nxt;
  logic [15:0]       lfsr, lfsr_nxt;
  logic [15:0]       phase, cnt, len_q, inc;
  logic              pcnt;
  logic              accept, step, run_step, last;
  logic signed [7:0] lbyte, r0, r1, r2, r1h, r2q, tone_v, data_nxt;
  logic signed [9:0] p, sum;

  // Quarter-wave table, k = 0..16, of round(48*sin(2*pi*k/64)).
  function automatic logic [5:0] quarter(input logic [4:0] i);
    case (i)
      5'd0:  quarter = 6'd0;
      5'd1:  quarter = 6'd5;
      5'd2:  quarter = 6'd9;
      5'd3:  quarter = 6'd14;
      5'd4:  quarter = 6'd18;
      5'd5:  quarter = 6'd23;
      5'd6:  quarter = 6'd27;
      5'd7:  quarter = 6'd30;
      5'd8:  quarter = 6'd34;
      5'd9:  quarter = 6'd37;
      5'd10: quarter = 6'd40;
      5'd11: quarter = 6'd42;
      5'd12: quarter = 6'd44;
      5'd13: quarter = 6'd46;
      5'd14: quarter = 6'd47;
      5'd15: quarter = 6'd48;
      5'd16: quarter = 6'd48;
      default: quarter = 6'd0;
    endcase
  endfunction

  function automatic logic signed [7:0] tone(input logic [5:0] idx);
    logic [4:0] qi;
    logic [7:0] mag;
    qi   = idx[4] ? 5'(6'd32 - {1'b0, idx[4:0]}) : idx[4:0];
    mag  = {2'b00, quarter(qi)};
    tone = idx[5] ? -$signed(mag) : $signed(mag);
  endfunction

  assign accept   = (state == IDLE) && start;
  assign step     = sample_en && ((state == PRIME) || (state == RUN));
  assign run_step = sample_en && (state == RUN);
  assign last     = (len_q != 16'd0) && ((cnt + 16'd1) == len_q);

  assign lfsr_nxt = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  assign lbyte    = lfsr_nxt[7:0];
  assign r0       = lbyte >>> 2;
  assign r1h      = r1 >>> 1;
  assign r2q      = r2 >>> 2;
  assign p        = {{2{r0[7]}}, r0} - {{2{r1h[7]}}, r1h} + {{2{r2q[7]}}, r2q};

  assign tone_v   = tone(phase[15:10]);
  assign sum      = {{2{tone_v[7]}}, tone_v} + p;
  assign data_nxt = (sum > 10'sd127)  ? 8'sd127 :
                    (sum < -10'sd128) ? -8'sd128 : sum[7:0];

  assign busy = (state == PRIME) || (state == RUN);
  assign done = (state == DONE);

`ifdef LMS_SRC_SWEEP_EN
  always_ff @(posedge clk) begin
    if (rst || accept) inc <= PHASE_INC;
    else if (run_step) inc <= inc + 16'd1;
  end
`else
  assign inc = PHASE_INC;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = PRIME;
      PRIME: begin
        if (stop)             state_nxt = DONE;
        else if (step && pcnt) state_nxt = RUN;
      end
      RUN: begin
        if (stop || (run_step && last)) state_nxt = DONE;
      end
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr     <= NOISE_SEED;
      phase    <= 16'd0;
      cnt      <= 16'd0;
      len_q    <= 16'd0;
      pcnt     <= 1'b0;
      r1       <= 8'sd0;
      r2       <= 8'sd0;
      data     <= 8'sd0;
      ref_data <= 8'sd0;
      clean    <= 8'sd0;
      valid    <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (accept) begin
        len_q <= burst_len;
        phase <= 16'd0;
        cnt   <= 16'd0;
        pcnt  <= 1'b0;
        r1    <= 8'sd0;
        r2    <= 8'sd0;
      end
      if (step) begin
        lfsr <= lfsr_nxt;
        r1   <= r0;
        r2   <= r1;
        if (state == PRIME) pcnt <= 1'b1;
      end
      // Outputs only move on RUN steps; PRIME merely fills the delay line.
      if (run_step) begin
        clean    <= tone_v;
        data     <= data_nxt;
        ref_data <= r0;
        valid    <= 1'b1;
        phase    <= phase + inc;
        cnt      <= cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_lms_src_gen.sv
// Directed bench for lms_src_gen: a reference model pushes expected samples on each RUN strobe, popped on valid.
module tb_lms_src_gen;

  localparam logic [15:0] PINC = 16'd1024;
  localparam logic [15:0] SEED = 16'hACE1;

  logic              clk = 1'b0;
  logic              rst, start, stop, sample_en;
  logic [15:0]       burst_len;
  logic signed [7:0] data, ref_data, clean;
  logic              valid, busy, done;

  always #5 clk = ~clk;

  lms_src_gen #(.PHASE_INC(PINC), .NOISE_SEED(SEED)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .sample_en(sample_en),
    .burst_len(burst_len), .data(data), .ref_data(ref_data), .clean(clean),
    .valid(valid), .busy(busy), .done(done)
  );

  typedef struct { int d; int r; int c; } smp_t;
  smp_t sbq[$];

  int ncmp = 0, nerr = 0;
  int lut[64];
  int ms, mr1, mr2, mpc;
  logic [15:0] ml, mph, minc, mcnt, mlen;
  int hd, hr, hc, vcnt, dcnt;
  int obs_d[128], obs_r[128], obs_c[128];

  task automatic chk(input string tag, input logic signed [31:0] o, input logic signed [31:0] e);
    ncmp++;
    assert (o === e) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, o, e);
    end
  endtask

  task automatic cyc(input bit i_rst, input bit i_start, input bit i_stop, input bit i_se);
    smp_t s;
    logic evld, fb;
    byte  b;
    int   r0, p, sm;
    rst = i_rst; start = i_start; stop = i_stop; sample_en = i_se;
    evld = 1'b0;
    if (i_rst) begin
      ms = 0; ml = SEED; mr1 = 0; mr2 = 0; mph = 0; mcnt = 0; mpc = 0; minc = PINC;
      hd = 0; hr = 0; hc = 0;
      sbq.delete();
    end else begin
      case (ms)
        0: if (i_start) begin
          mlen = burst_len; mph = 0; mcnt = 0; mr1 = 0; mr2 = 0; mpc = 0; minc = PINC; ms = 1;
        end
        1, 2: begin
          if (i_se) begin
            fb = ml[0] ^ ml[2] ^ ml[3] ^ ml[5];
            ml = {fb, ml[15:1]};
            b  = ml[7:0];
            r0 = int'(b) >>> 2;
            p  = r0 - (mr1 >>> 1) + (mr2 >>> 2);
            if (ms == 2) begin
              s.c = lut[mph[15:10]];
              sm  = s.c + p;
              s.d = (sm > 127) ? 127 : ((sm < -128) ? -128 : sm);
              s.r = r0;
              sbq.push_back(s);
              evld = 1'b1;
              mph  = mph + minc;
`ifdef LMS_SRC_SWEEP_EN
              minc = minc + 16'd1;
`endif
              mcnt = mcnt + 16'd1;
              if (mlen != 16'd0 && mcnt == mlen) ms = 3;
            end else begin
              if (mpc == 1) ms = 2;
              mpc = 1;
            end
            mr2 = mr1;
            mr1 = r0;
          end
          if (i_stop) ms = 3;
        end
        default: ms = 0;
      endcase
    end
    @(posedge clk);
    #1;
    chk("valid", valid, evld);
    if (sbq.size() > 0) begin
      s = sbq.pop_front();
      if (valid === 1'b1) begin
        hd = s.d; hr = s.r; hc = s.c;
        if (vcnt < 128) begin
          obs_d[vcnt] = data; obs_r[vcnt] = ref_data; obs_c[vcnt] = clean;
        end
        vcnt++;
      end
    end
    chk("data", data, hd);
    chk("ref_data", ref_data, hr);
    chk("clean", clean, hc);
    chk("busy", busy, (ms == 1 || ms == 2) ? 1 : 0);
    chk("done", done, (ms == 3) ? 1 : 0);
    if (done === 1'b1) dcnt++;
  endtask

  initial begin
    for (int k = 0; k < 64; k++)
      lut[k] = int'(48.0 * $sin(2.0 * 3.141592653589793 * k / 64.0));
    rst = 1'b1; start = 1'b0; stop = 1'b0; sample_en = 1'b0; burst_len = 16'd0;
    vcnt = 0; dcnt = 0;

    // Reset state
    repeat (3) cyc(1, 0, 0, 0);

    // Four-sample burst, strobe held high
    burst_len = 16'd4; vcnt = 0; dcnt = 0;
    cyc(0, 1, 0, 1);
    chk("t1_busy_rise", busy, 1);
    repeat (8) cyc(0, 0, 0, 1);
    chk("t1_first_ref", obs_r[0], -25);
    chk("t1_first_clean", obs_c[0], 0);
    chk("t1_first_data", obs_d[0], -25);
    chk("t1_nvalid", vcnt, 4);
    chk("t1_ndone", dcnt, 1);

    // Continuous run, then stop coinciding with a step
    burst_len = 16'd0; vcnt = 0; dcnt = 0;
    cyc(0, 1, 0, 1);
    repeat (82) cyc(0, 0, 0, 1);
    cyc(0, 0, 1, 1);
    repeat (2) cyc(0, 0, 0, 0);
    chk("t2_nvalid", vcnt, 81);
    chk("t2_ndone", dcnt, 1);
`ifndef LMS_SRC_SWEEP_EN
    chk("t2_clean16", obs_c[16], 48);
    chk("t2_clean48", obs_c[48], -48);
    chk("t2_clean64", obs_c[64], 0);
    chk("t2_clean80", obs_c[80], 48);
`endif

    // Strobe 1-of-3, burst of five; burst_len change mid-burst is ignored
    burst_len = 16'd5; vcnt = 0; dcnt = 0;
    cyc(0, 1, 0, 0);
    for (int i = 0; i < 30; i++) begin
      if (i == 3) burst_len = 16'd2;
      cyc(0, 0, 0, (i % 3) == 0);
    end
    chk("t3_nvalid", vcnt, 5);
    chk("t3_ndone", dcnt, 1);
    chk("t3_busy_end", busy, 0);

    // Stop on the third RUN step
    burst_len = 16'd0; vcnt = 0; dcnt = 0;
    cyc(0, 1, 0, 1);
    repeat (4) cyc(0, 0, 0, 1);
    cyc(0, 0, 1, 1);
    repeat (4) cyc(0, 0, 0, 1);
    chk("t4_nvalid", vcnt, 3);
    chk("t4_ndone", dcnt, 1);

    // Reset mid-burst (start during RUN ignored), then rerun
    burst_len = 16'd0; vcnt = 0; dcnt = 0;
    cyc(0, 1, 0, 1);
    repeat (5) cyc(0, 0, 0, 1);
    cyc(0, 1, 0, 1);
    cyc(1, 0, 0, 1);
    cyc(1, 0, 0, 0);
    chk("t5_no_done_on_rst", dcnt, 0);
    burst_len = 16'd3; vcnt = 0;
    cyc(0, 1, 0, 1);
    repeat (6) cyc(0, 0, 0, 1);
    chk("t5_rerun_data", obs_d[0], -25);
    chk("t5_rerun_ref", obs_r[0], -25);
    chk("t5_nvalid", vcnt, 3);
    chk("t5_ndone", dcnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
